// File: rtl/rdm_data_server_if.sv
// rdm_data_server_if: code-block control, RDM data request bus and sample-buffer read port
interface rdm_data_server_if #(parameter int ADDR_W = 12);
  logic              i_rdm_slot_start;
  logic              i_cb_start;
  logic [ADDR_W-1:0] i_cb_base_addr;
  logic [11:0]       i_cb_words;
  logic              i_rdm_data_request;
  logic [3:0]        i_rdm_data_amount;
  logic              i_rdm_data_permit;
  logic              o_buf_rd_en;
  logic [ADDR_W-1:0] o_buf_rd_addr;
  logic [95:0]       i_buf_rd_data;
  logic              o_rdm_data_valid;
  logic [95:0]       o_rdm_data_content;
  logic              o_rdm_data_comp;
  logic              o_busy;
  logic              o_req_err;
  modport slave (
    input  i_rdm_slot_start, i_cb_start, i_cb_base_addr, i_cb_words,
    input  i_rdm_data_request, i_rdm_data_amount, i_rdm_data_permit, i_buf_rd_data,
    output o_buf_rd_en, o_buf_rd_addr, o_rdm_data_valid, o_rdm_data_content,
    output o_rdm_data_comp, o_busy, o_req_err
  );
  modport master (
    output i_rdm_slot_start, i_cb_start, i_cb_base_addr, i_cb_words,
    output i_rdm_data_request, i_rdm_data_amount, i_rdm_data_permit, i_buf_rd_data,
    input  o_buf_rd_en, o_buf_rd_addr, o_rdm_data_valid, o_rdm_data_content,
    input  o_rdm_data_comp, o_busy, o_req_err
  );
endinterface

// File: rtl/rdm_data_server.sv
// rdm_data_server: serves code-block words from the sample buffer to the combine FSM via a skid FIFO
module rdm_data_server #(
  parameter int ADDR_W     = 12,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic              i_core_clk,
  input logic              i_rx_rstn,
  rdm_data_server_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;
  typedef enum logic [1:0] {IDLE, WAIT_REQ, STREAM, COMPLETE} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] rd_addr;
  logic [11:0]       remaining;
  logic [4:0]        burst_left, issue_left, amt, clip;
  logic [RAM_LAT-1:0] pipe;
  logic [95:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count, inflight;
  logic [95:0]       out_data;
  logic              flush, rd_en, push, pop, req, start, stream_done;
  logic              out_valid, comp, req_err;
  assign flush       = bus.i_rdm_slot_start;
  assign amt         = bus.i_rdm_data_amount == 4'd0 ? 5'd16 : {1'b0, bus.i_rdm_data_amount};
  assign clip        = remaining < 12'(amt) ? remaining[4:0] : amt;
  assign start       = state == IDLE && bus.i_cb_start;
  assign req         = state == WAIT_REQ && bus.i_rdm_data_request;
  assign push        = pipe[RAM_LAT-1];
  assign pop         = fifo_count != '0 && bus.i_rdm_data_permit;
  // reads in flight reserve FIFO slots so a returning word always has room
  assign rd_en       = state == STREAM && issue_left != '0 && fifo_count + inflight < CW'(FIFO_DEPTH);
  assign stream_done = burst_left == '0 && fifo_count == '0 && pipe == '0 && !out_valid;
  always_comb begin
    inflight = '0;
    for (int k = 0; k < RAM_LAT; k++) inflight = inflight + CW'(pipe[k]);
  end
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (start) state_nx = bus.i_cb_words == '0 ? COMPLETE : WAIT_REQ;
    else if (req) state_nx = STREAM;
    else if (state == STREAM && stream_done) state_nx = remaining == '0 ? COMPLETE : WAIT_REQ;
    else if (state == COMPLETE) state_nx = IDLE;
  end
  always_ff @(posedge i_core_clk or negedge i_rx_rstn)
    if (!i_rx_rstn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge i_core_clk)
    if (push) mem[wr_ptr] <= bus.i_buf_rd_data;
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      rd_addr    <= '0;
      remaining  <= '0;
      burst_left <= '0;
      issue_left <= '0;
      pipe       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      comp       <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      out_valid <= pop && !flush;
      comp      <= state == COMPLETE && !flush;
      req_err   <= bus.i_rdm_data_request && !flush && state != WAIT_REQ;
      if (pop) out_data <= mem[rd_ptr];
      if (flush) begin
        pipe       <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        burst_left <= '0;
        issue_left <= '0;
        remaining  <= '0;
      end else begin
        pipe[0] <= rd_en;
        for (int k = 1; k < RAM_LAT; k++) pipe[k] <= pipe[k-1];
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (start) begin
          rd_addr   <= bus.i_cb_base_addr;
          remaining <= bus.i_cb_words;
        end else begin
          if (out_valid) remaining <= remaining - 12'd1;
          if (rd_en) rd_addr <= rd_addr + ADDR_W'(1);
        end
        if (req) begin
          burst_left <= clip;
          issue_left <= clip;
        end else begin
          if (out_valid) burst_left <= burst_left - 5'd1;
          if (rd_en) issue_left <= issue_left - 5'd1;
        end
      end
    end
  end
  assign bus.o_buf_rd_en        = rd_en;
  assign bus.o_buf_rd_addr      = rd_addr;
  assign bus.o_rdm_data_valid   = out_valid;
  assign bus.o_rdm_data_content = out_data;
  assign bus.o_rdm_data_comp    = comp;
  assign bus.o_busy             = state != IDLE;
  assign bus.o_req_err          = req_err;
endmodule

// File: tb/tb_rdm_data_server.sv
// tb_rdm_data_server: directed scenarios against a latency-accurate sample-buffer model
module tb_rdm_data_server;
  localparam int LAT = 3;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  rdm_data_server_if #(.ADDR_W(12)) bus ();
  rdm_data_server #(.ADDR_W(12), .RAM_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .i_core_clk(clk), .i_rx_rstn(rstn), .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  function automatic logic [95:0] word(input logic [11:0] a);
    return {32'(a) * 32'h9E3779B1, ~{20'h0, a}, {20'h0, a}};
  endfunction
  logic [11:0] ap [LAT];
  bit av [LAT];
  always @(posedge clk) begin
    ap[0] <= bus.o_buf_rd_addr;
    av[0] <= bus.o_buf_rd_en;
    for (int k = 1; k < LAT; k++) begin
      ap[k] <= ap[k-1];
      av[k] <= av[k-1];
    end
  end
  assign bus.i_buf_rd_data = av[LAT-1] ? word(ap[LAT-1]) : '0;
  logic [11:0] got [$];
  logic [11:0] rd_q [$];
  int comps, reqerrs, coinc, perm_viol, bad_data;
  bit prev_permit;
  always @(negedge clk) begin
    if (bus.o_rdm_data_valid === 1'b1) begin
      got.push_back(bus.o_rdm_data_content[11:0]);
      if (bus.o_rdm_data_content !== word(bus.o_rdm_data_content[11:0])) bad_data++;
      if (!prev_permit) perm_viol++;
    end
    if (bus.o_rdm_data_comp === 1'b1) begin
      comps++;
      if (bus.o_rdm_data_valid === 1'b1) coinc++;
    end
    if (bus.o_req_err === 1'b1) reqerrs++;
    if (bus.o_buf_rd_en === 1'b1) rd_q.push_back(bus.o_buf_rd_addr);
    prev_permit = bus.i_rdm_data_permit;
  end
  function automatic int seq_bad(input logic [11:0] base, input int n);
    if (got.size() != n) return -2;
    for (int i = 0; i < n; i++) if (got[i] !== base + 12'(i)) return i;
    return -1;
  endfunction
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_mon();
    got.delete();
    rd_q.delete();
    comps = 0;
    reqerrs = 0;
    coinc = 0;
    perm_viol = 0;
    bad_data = 0;
  endtask
  task automatic start_cb(input logic [11:0] base, input logic [11:0] words);
    bus.i_cb_start = 1'b1;
    bus.i_cb_base_addr = base;
    bus.i_cb_words = words;
    step();
    bus.i_cb_start = 1'b0;
  endtask
  task automatic request(input logic [3:0] amount);
    bus.i_rdm_data_request = 1'b1;
    bus.i_rdm_data_amount = amount;
    step();
    bus.i_rdm_data_request = 1'b0;
  endtask
  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) step();
  endtask
  task automatic wait_comp(input int budget);
    for (int i = 0; i < budget && comps == 0; i++) step();
  endtask
  task automatic test_reset();
    #12;
    checks++; if (bus.o_rdm_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_rdm_data_valid); end
    checks++; if (bus.o_rdm_data_comp !== 1'b0) begin errors++; $display("FAIL reset_comp got=%b exp=0", bus.o_rdm_data_comp); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_req_err !== 1'b0) begin errors++; $display("FAIL reset_req_err got=%b exp=0", bus.o_req_err); end
    checks++; if (bus.o_buf_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", bus.o_buf_rd_en); end
    checks++; if (bus.o_rdm_data_content !== 96'h0) begin errors++; $display("FAIL reset_content got=%h exp=0", bus.o_rdm_data_content); end
    step();
    rstn = 1'b1;
    step(2);
  endtask
  task automatic test_single_burst();
    clear_mon();
    start_cb(12'h010, 12'd16);
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL t1_busy got=%b exp=1", bus.o_busy); end
    request(4'd0);
    wait_comp(200);
    checks++; if (seq_bad(12'h010, 16) != -1) begin errors++; $display("FAIL t1_order words=%0d bad_idx=%0d exp 16 from 010", got.size(), seq_bad(12'h010, 16)); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL t1_data bad=%0d exp=0", bad_data); end
    checks++; if (comps != 1) begin errors++; $display("FAIL t1_comp got=%0d exp=1", comps); end
    checks++; if (coinc != 0) begin errors++; $display("FAIL t1_comp_with_valid got=%0d exp=0", coinc); end
    step(2);
    checks++; if (bus.o_busy !== 1'b0 || comps != 1) begin errors++; $display("FAIL t1_idle busy=%b comps=%0d exp 0/1", bus.o_busy, comps); end
  endtask
  task automatic test_multi_burst();
    clear_mon();
    start_cb(12'h100, 12'd20);
    request(4'd8);
    wait_words(8, 100);
    step(4);
    checks++; if (got.size() != 8 || rd_q.size() != 8) begin errors++; $display("FAIL t2_burst1 words=%0d reads=%0d exp 8/8", got.size(), rd_q.size()); end
    checks++; if (bus.o_busy !== 1'b1 || comps != 0) begin errors++; $display("FAIL t2_wait busy=%b comps=%0d exp 1/0", bus.o_busy, comps); end
    request(4'd8);
    wait_words(16, 100);
    step(4);
    checks++; if (got.size() != 16 || rd_q.size() != 16) begin errors++; $display("FAIL t2_burst2 words=%0d reads=%0d exp 16/16", got.size(), rd_q.size()); end
    request(4'd8);
    wait_comp(100);
    step(2);
    checks++; if (seq_bad(12'h100, 20) != -1) begin errors++; $display("FAIL t2_order words=%0d bad_idx=%0d exp 20 from 100", got.size(), seq_bad(12'h100, 20)); end
    checks++; if (rd_q.size() != 20) begin errors++; $display("FAIL t2_reads got=%0d exp=20", rd_q.size()); end
    checks++; if (comps != 1 || coinc != 0 || reqerrs != 0) begin errors++; $display("FAIL t2_comp comps=%0d coinc=%0d reqerr=%0d exp 1/0/0", comps, coinc, reqerrs); end
  endtask
  task automatic test_permit_toggle();
    int wait_cnt;
    bit sent2;
    clear_mon();
    start_cb(12'h200, 12'd24);
    request(4'd0);
    wait_cnt = 0;
    sent2 = 1'b0;
    for (int c = 0; c < 600 && comps == 0; c++) begin
      bus.i_rdm_data_permit = ((c / 3) % 2) == 0;
      bus.i_rdm_data_request = 1'b0;
      if (!sent2 && got.size() >= 16 && ++wait_cnt == 4) begin
        bus.i_rdm_data_request = 1'b1;
        bus.i_rdm_data_amount = 4'd0;
        sent2 = 1'b1;
      end
      step();
    end
    bus.i_rdm_data_request = 1'b0;
    bus.i_rdm_data_permit = 1'b1;
    step(2);
    checks++; if (seq_bad(12'h200, 24) != -1) begin errors++; $display("FAIL t3_order words=%0d bad_idx=%0d exp 24 from 200", got.size(), seq_bad(12'h200, 24)); end
    checks++; if (perm_viol != 0) begin errors++; $display("FAIL t3_permit late_words=%0d exp=0", perm_viol); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL t3_data bad=%0d exp=0", bad_data); end
    checks++; if (comps != 1 || reqerrs != 0) begin errors++; $display("FAIL t3_comp comps=%0d reqerr=%0d exp 1/0", comps, reqerrs); end
  endtask
  task automatic test_wrap();
    clear_mon();
    start_cb(12'hFFE, 12'd4);
    request(4'd0);
    wait_comp(100);
    checks++; if (rd_q.size() != 4 || rd_q[0] !== 12'hFFE || rd_q[1] !== 12'hFFF || rd_q[2] !== 12'h000 || rd_q[3] !== 12'h001) begin
      errors++; $display("FAIL t4_rd_addr n=%0d first=%h last=%h exp FFE..001", rd_q.size(), rd_q.size() ? rd_q[0] : 12'h0, rd_q.size() ? rd_q[rd_q.size()-1] : 12'h0); end
    checks++; if (seq_bad(12'hFFE, 4) != -1) begin errors++; $display("FAIL t4_order words=%0d bad_idx=%0d exp FFE..001", got.size(), seq_bad(12'hFFE, 4)); end
    step(2);
  endtask
  task automatic test_req_err();
    clear_mon();
    start_cb(12'h300, 12'd12);
    request(4'd8);
    request(4'd3);
    step();
    checks++; if (reqerrs != 1) begin errors++; $display("FAIL t5_stream_req_err got=%0d exp=1", reqerrs); end
    wait_words(8, 100);
    step(4);
    checks++; if (got.size() != 8 || rd_q.size() != 8) begin errors++; $display("FAIL t5_burst_kept words=%0d reads=%0d exp 8/8", got.size(), rd_q.size()); end
    request(4'd0);
    wait_comp(100);
    checks++; if (seq_bad(12'h300, 12) != -1) begin errors++; $display("FAIL t5_order words=%0d bad_idx=%0d exp 12 from 300", got.size(), seq_bad(12'h300, 12)); end
    step(2);
    clear_mon();
    bus.i_rdm_data_request = 1'b1;
    start_cb(12'h050, 12'd0);
    bus.i_rdm_data_request = 1'b0;
    checks++; if (bus.o_req_err !== 1'b1) begin errors++; $display("FAIL t5_idle_req_err got=%b exp=1", bus.o_req_err); end
    checks++; if (bus.o_rdm_data_comp !== 1'b0) begin errors++; $display("FAIL t5_comp_early got=%b exp=0", bus.o_rdm_data_comp); end
    step();
    checks++; if (bus.o_rdm_data_comp !== 1'b1) begin errors++; $display("FAIL t5_comp_zero got=%b exp=1", bus.o_rdm_data_comp); end
    step();
    checks++; if (bus.o_rdm_data_comp !== 1'b0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL t5_comp_end comp=%b busy=%b exp 0/0", bus.o_rdm_data_comp, bus.o_busy); end
    checks++; if (got.size() != 0 || rd_q.size() != 0) begin errors++; $display("FAIL t5_zero_words words=%0d reads=%0d exp 0/0", got.size(), rd_q.size()); end
  endtask
  task automatic test_flush();
    clear_mon();
    start_cb(12'h400, 12'd16);
    request(4'd0);
    step(2);
    bus.i_rdm_slot_start = 1'b1;
    step();
    bus.i_rdm_slot_start = 1'b0;
    checks++; if (bus.o_busy !== 1'b0 || bus.o_rdm_data_valid !== 1'b0) begin errors++; $display("FAIL t6_flush busy=%b valid=%b exp 0/0", bus.o_busy, bus.o_rdm_data_valid); end
    clear_mon();
    step(20);
    checks++; if (got.size() != 0 || comps != 0 || rd_q.size() != 0) begin errors++; $display("FAIL t6_quiet words=%0d comps=%0d reads=%0d exp 0/0/0", got.size(), comps, rd_q.size()); end
    start_cb(12'h500, 12'd5);
    request(4'd0);
    wait_comp(100);
    checks++; if (seq_bad(12'h500, 5) != -1 || bad_data != 0) begin errors++; $display("FAIL t6_restart words=%0d bad_idx=%0d bad=%0d exp 5 from 500", got.size(), seq_bad(12'h500, 5), bad_data); end
    step(2);
  endtask
  task automatic test_async_reset();
    clear_mon();
    start_cb(12'h600, 12'd16);
    request(4'd0);
    step(6);
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.o_rdm_data_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_buf_rd_en !== 1'b0) begin
      errors++; $display("FAIL t7_async valid=%b busy=%b rd_en=%b exp 0/0/0", bus.o_rdm_data_valid, bus.o_busy, bus.o_buf_rd_en); end
    step();
    rstn = 1'b1;
    step(6);
    clear_mon();
    start_cb(12'h700, 12'd3);
    request(4'd0);
    wait_comp(100);
    checks++; if (seq_bad(12'h700, 3) != -1 || bad_data != 0) begin errors++; $display("FAIL t7_restart words=%0d bad_idx=%0d bad=%0d exp 3 from 700", got.size(), seq_bad(12'h700, 3), bad_data); end
    step(2);
  endtask
  initial begin
    bus.i_rdm_slot_start = 1'b0;
    bus.i_cb_start = 1'b0;
    bus.i_cb_base_addr = '0;
    bus.i_cb_words = '0;
    bus.i_rdm_data_request = 1'b0;
    bus.i_rdm_data_amount = '0;
    bus.i_rdm_data_permit = 1'b1;
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_permit_toggle();
    test_wrap();
    test_req_err();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
